fifo_reader: RTL and testbench

// - Read-side consumer for fifo_flops: pops words while pndng is high, buffers them in a
//   2-entry output stage and presents them on a valid/ready stream to downstream logic.
// - Full throughput (1 word/cycle) with no combinational path from out_ready to pop.
// - Keeps a running count of words delivered, for scoreboard cross-checks.

---
 rtl/fifo_reader.sv | 162 ++++++++++++++++
 tb/tb_fifo_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side consumer for a show-ahead FIFO (fifo_flops). It pops words while
// the FIFO reports pending data and holds them in a 2-entry output stage. The
// words are presented on a valid/ready stream. It also keeps a running count
// of the words delivered.
//
// Ports
//   clk         in   1      clock, all state changes on posedge
//   rst         in   1      synchronous reset, active-high
//   rd_en       in   1      1 = reader may pop new words
//   pndng       in   1      FIFO not empty, Dout holds the head word
//   Dout        in   width  FIFO head word (show-ahead)
//   pop         out  1      combinational, pops the FIFO head at this posedge
//   out_valid   out  1      out_data holds a valid word
//   out_ready   in   1      downstream accepts when out_valid & out_ready
//   out_data    out  width  oldest buffered word
//   word_count  out  cnt_w  number of output handshakes since reset (wraps)
//   out_parity  out  1      even parity of out_data (FIFO_READER_PARITY_EN only)
//
// Configuration
//   FIFO_READER_PARITY_EN : when defined, adds the registered out_parity port.
// -----------------------------------------------------------------------------
module fifo_reader #(
  parameter int width = 16,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic             pndng,
  input  logic [width-1:0] Dout,
  output logic             pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [cnt_w-1:0] word_count
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  // Buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_r;
  logic [width-1:0]   head_r;
  logic [width-1:0]   tail_r;
  logic               valid_r;
  logic [cnt_w-1:0]   count_r;
  logic               take_s;
  logic               give_s;
  logic               head_ld_s;
  logic [width-1:0]   head_nxt_s;

`ifdef FIFO_READER_PARITY_EN
  logic               parity_r;

  // Even parity: 1 when the word has an odd number of ones
  function automatic logic parity_f(input logic [width-1:0] d);
    return ^d;
  endfunction
`endif

  // Pop only from registered state and inputs, never from out_ready, so the
  // downstream ready path does not reach the FIFO combinationally.
  assign take_s = rd_en & pndng & (state_r != ST_TWO) & ~rst;
  assign give_s = valid_r & out_ready;
  assign pop    = take_s;

  // Head slot load: a fresh word enters the head when the buffer is empty or
  // when the current head leaves in the same cycle; from TWO the tail advances.
  always_comb begin
    head_ld_s  = 1'b0;
    head_nxt_s = Dout;
    case (state_r)
      ST_EMPTY: begin
        head_ld_s  = take_s;
        head_nxt_s = Dout;
      end
      ST_ONE: begin
        head_ld_s  = take_s & give_s;
        head_nxt_s = Dout;
      end
      ST_TWO: begin
        head_ld_s  = give_s;
        head_nxt_s = tail_r;
      end
      default: begin
        head_ld_s  = 1'b0;
        head_nxt_s = Dout;
      end
    endcase
  end

  // Occupancy FSM, output stage registers and delivered-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      head_r  <= {width{1'b0}};
      tail_r  <= {width{1'b0}};
      valid_r <= 1'b0;
      count_r <= {cnt_w{1'b0}};
`ifdef FIFO_READER_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      if (give_s) begin
        count_r <= count_r + {{(cnt_w-1){1'b0}}, 1'b1};
      end

      if (head_ld_s) begin
        head_r <= head_nxt_s;
`ifdef FIFO_READER_PARITY_EN
        parity_r <= parity_f(head_nxt_s);
`endif
      end

      case (state_r)
        ST_EMPTY: begin
          if (take_s) begin
            state_r <= ST_ONE;
            valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (take_s && !give_s) begin
            tail_r  <= Dout;
            state_r <= ST_TWO;
          end else if (!take_s && give_s) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (give_s) begin
            state_r <= ST_ONE;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = valid_r;
  assign out_data   = head_r;
  assign word_count = count_r;
`ifdef FIFO_READER_PARITY_EN
  assign out_parity = parity_r;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
// Directed bench for fifo_reader. A queue models the show-ahead FIFO feeding
// the reader; delivered words are collected and compared with hand-computed
// expected values.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        pndng;
  logic [15:0] Dout;
  logic        pop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] word_count;
`ifdef FIFO_READER_PARITY_EN
  logic        out_parity;
`endif

  int          tests_run    = 0;
  int          tests_failed = 0;

  logic [15:0] fq[$];
  logic [15:0] got[$];

  // Values observed in the cycle before the most recent posedge
  logic        s_pop;
  logic        s_valid;
  logic        s_give;
  logic [15:0] s_data;
  logic [15:0] s_count;

  fifo_reader #(.width(16), .cnt_w(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .pndng      (pndng),
    .Dout       (Dout),
    .pop        (pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
`ifdef FIFO_READER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive_fifo();
    if (fq.size() != 0) begin
      pndng = 1'b1;
      Dout  = fq[0];
    end else begin
      pndng = 1'b0;
      Dout  = 16'hDEAD;
    end
  endtask

  // One clock: sample at negedge, let the edge happen, then update the FIFO model
  task automatic tick();
    @(negedge clk);
    s_pop   = pop;
    s_valid = out_valid;
    s_give  = out_valid & out_ready;
    s_data  = out_data;
    s_count = word_count;
    @(posedge clk);
    #1;
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    if (s_give) got.push_back(s_data);
    drive_fifo();
  endtask

  task automatic test_reset();
    fq.delete();
    fq.push_back(16'h1111);
    rd_en     = 1'b1;
    out_ready = 1'b1;
    drive_fifo();
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (s_pop !== 1'b0 || s_valid !== 1'b0 || s_data !== 16'h0000 || s_count !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset cyc%0d: pop=%b valid=%b data=%h cnt=%h, required 0 0 0000 0000",
                 c, s_pop, s_valid, s_data, s_count);
      end
    end
    fq.delete();
    drive_fifo();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_stream();
    got.delete();
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    rd_en     = 1'b1;
    out_ready = 1'b1;
    drive_fifo();
    tick();
    tests_run++;
    if (s_pop !== 1'b1 || s_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_first_pop: pop=%b valid=%b, required 1 0", s_pop, s_valid);
    end
    tick();
    tests_run++;
    if (s_valid !== 1'b1 || s_data !== 16'h0001 || s_pop !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_latency: valid=%b data=%h pop=%b, required 1 0001 1", s_valid, s_data, s_pop);
    end
    for (int i = 0; i < 20 && got.size() < 8; i++) tick();
    tests_run++;
    if (got.size() != 8) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d words, required 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got[i] !== 16'(i + 1)) begin
          tests_failed++;
          $display("FAIL stream_order[%0d]: got %h, required %h", i, got[i], 16'(i + 1));
        end
      end
    end
    tests_run++;
    if (word_count !== 16'd8) begin
      tests_failed++;
      $display("FAIL stream_word_count: got %0d, required 8", word_count);
    end
  endtask

  task automatic test_backpressure();
    int npops;
    got.delete();
    rd_en     = 1'b1;
    out_ready = 1'b0;
    fq.push_back(16'hA5A5);
    fq.push_back(16'h5A5A);
    fq.push_back(16'h1234);
    drive_fifo();
    npops = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_pop) npops++;
    end
    tests_run++;
    if (npops != 2 || fq.size() != 1) begin
      tests_failed++;
      $display("FAIL bp_pops: pops=%0d left=%0d, required 2 1", npops, fq.size());
    end
    tests_run++;
    if (s_valid !== 1'b1 || s_data !== 16'hA5A5 || s_pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold: valid=%b data=%h pop=%b, required 1 a5a5 0", s_valid, s_data, s_pop);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) tick();
    tests_run++;
    if (got.size() != 3 || got[0] !== 16'hA5A5 || got[1] !== 16'h5A5A || got[2] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL bp_order: got %0d words, required a5a5 5a5a 1234", got.size());
    end
    tests_run++;
    if (word_count !== 16'd11) begin
      tests_failed++;
      $display("FAIL bp_word_count: got %0d, required 11", word_count);
    end
  endtask

  task automatic test_rd_en_drop();
    got.delete();
    rd_en     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(16'h0100 + 16'(i));
    drive_fifo();
    tick();
    tick();
    rd_en = 1'b0;
    tick();
    tests_run++;
    if (s_pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL rden_stop: pop=%b, required 0", s_pop);
    end
    tick();
    tick();
    tests_run++;
    if (got.size() != 2 || fq.size() != 6 || s_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rden_drain: delivered=%0d left=%0d valid=%b, required 2 6 0",
               got.size(), fq.size(), s_valid);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 30 && got.size() < 8; i++) tick();
    tick();
    tick();
    tests_run++;
    if (got.size() != 8 || fq.size() != 0) begin
      tests_failed++;
      $display("FAIL rden_resume: delivered=%0d left=%0d, required 8 0", got.size(), fq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got[i] !== 16'h0100 + 16'(i)) begin
          tests_failed++;
          $display("FAIL rden_order[%0d]: got %h, required %h", i, got[i], 16'h0100 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt[3];
    int          seen;
    exp_cnt[0] = 16'hFFFF;
    exp_cnt[1] = 16'h0000;
    exp_cnt[2] = 16'h0001;
    got.delete();
    force dut.count_r = 16'hFFFE;
    #1;
    release dut.count_r;
    #1;
    tests_run++;
    if (word_count !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL wrap_preload: got %h, required fffe", word_count);
    end
    rd_en     = 1'b1;
    out_ready = 1'b1;
    fq.push_back(16'h0A01);
    fq.push_back(16'h0A02);
    fq.push_back(16'h0A03);
    drive_fifo();
    seen = 0;
    for (int i = 0; i < 10 && seen < 3; i++) begin
      tick();
      if (got.size() > seen) begin
        tests_run++;
        if (word_count !== exp_cnt[seen]) begin
          tests_failed++;
          $display("FAIL wrap_count[%0d]: got %h, required %h", seen, word_count, exp_cnt[seen]);
        end
        seen++;
      end
    end
    tests_run++;
    if (seen != 3) begin
      tests_failed++;
      $display("FAIL wrap_handshakes: got %0d, required 3", seen);
    end
  endtask

  task automatic test_reset_in_two();
    got.delete();
    rd_en     = 1'b1;
    out_ready = 1'b0;
    fq.push_back(16'hC001);
    fq.push_back(16'hC002);
    fq.push_back(16'hC003);
    fq.push_back(16'hC004);
    drive_fifo();
    tick();
    tick();
    tick();
    tests_run++;
    if (s_pop !== 1'b0 || s_valid !== 1'b1 || fq.size() != 2) begin
      tests_failed++;
      $display("FAIL rst2_setup: pop=%b valid=%b left=%0d, required 0 1 2", s_pop, s_valid, fq.size());
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (s_pop !== 1'b0 || out_valid !== 1'b0 || word_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst2_clear: pop=%b valid=%b cnt=%h, required 0 0 0000", s_pop, out_valid, word_count);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (s_valid !== 1'b0 || s_pop !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst2_resume: valid=%b pop=%b, required 0 1", s_valid, s_pop);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 2; i++) tick();
    tick();
    tick();
    tests_run++;
    if (got.size() != 2 || got[0] !== 16'hC003 || got[1] !== 16'hC004) begin
      tests_failed++;
      $display("FAIL rst2_order: delivered=%0d, required c003 c004 only", got.size());
    end
  endtask

`ifdef FIFO_READER_PARITY_EN
  task automatic test_parity();
    got.delete();
    rd_en     = 1'b1;
    out_ready = 1'b0;
    fq.push_back(16'h0007);
    fq.push_back(16'h0003);
    drive_fifo();
    tick();
    tick();
    tests_run++;
    if (out_data !== 16'h0007 || out_parity !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_odd: data=%h par=%b, required 0007 1", out_data, out_parity);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data !== 16'h0003 || out_parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_even: data=%h par=%b, required 0003 0", out_data, out_parity);
    end
    for (int i = 0; i < 5; i++) tick();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    rd_en     = 1'b0;
    out_ready = 1'b0;
    pndng     = 1'b0;
    Dout      = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_rd_en_drop();
    test_wrap();
    test_reset_in_two();
`ifdef FIFO_READER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
